// File: rtl/rr_arb_mux.sv
// N-channel arbitrating mux (fixed priority or round-robin) into a one-beat output register.
// Latency: 1 cycle from input handshake to out_*; full throughput with simultaneous drain/load.
// Backpressure: out_valid & !out_ready freezes the held beat and forces in_ready to zero.
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mode,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [SELW-1:0]   r_out_sel;
    logic [SELW-1:0]   r_ptr;

    logic              w_load_en;
    logic              w_any_req;
    logic              w_grant_vld;
    logic [SELW-1:0]   w_lo_idx;
    logic              w_hi_found;
    logic [SELW-1:0]   w_hi_idx;
    logic [SELW-1:0]   w_grant;
    logic [SELW-1:0]   w_ptr_next;

    assign w_load_en = !r_out_valid || out_ready;
    assign w_any_req = |in_valid;

    // Lowest requester overall doubles as the fixed-priority winner and the round-robin wrap winner.
    always_comb begin
        w_lo_idx   = '0;
        w_hi_idx   = '0;
        w_hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                w_lo_idx = SELW'(i);
                if (i >= int'(r_ptr)) begin
                    w_hi_idx   = SELW'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_grant = w_lo_idx;
        if (mode && w_hi_found) begin
            w_grant = w_hi_idx;
        end
    end

    assign w_grant_vld = reset_n && w_load_en && w_any_req;
    assign in_ready    = w_grant_vld ? (N'(1) << w_grant) : '0;
    assign w_ptr_next  = (w_grant == SELW'(N - 1)) ? '0 : w_grant + SELW'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_grant_vld) begin
                r_out_valid <= 1'b1;
                r_out_data  <= in_data[int'(w_grant)*WIDTH +: WIDTH];
                r_out_sel   <= w_grant;
                if (mode) begin
                    r_ptr <= w_ptr_next;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
